// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] instr;
    logic                  zero;
    logic                  mem_ready;

    logic                  PCWrite;
    logic                  IRWrite;
    logic                  AdrSrc;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  RegWrite;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUctrl;
    logic [1:0]            ResultSrc;
    logic [1:0]            ImmSrc;
    logic                  illegal;
    logic                  retire;

    modport master (
        input  instr, zero, mem_ready,
        output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc, illegal, retire
    );

    modport slave (
        output instr, zero, mem_ready,
        input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc, illegal, retire
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core (add, sub, addi, lw, sw, beq, bne).
// Outputs are pure state decodes, forced low while reset is asserted.
module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAdr, StMemRd,
        StMemWb, StMemWr, StAluWb, StBranch, StTrap
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] ir;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_store;
    logic                  unused_ir_bits;

    assign ir             = bus.instr;
    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign funct7         = ir[31:25];
    assign is_store       = ir[5];
    assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_ctrl;
    logic       illegal, retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        result_src = 2'b00;
        imm_src    = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = bus.mem_ready;
                ir_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target is computed here so BRANCH only needs the compare.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpImm:            state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAdr;
                    OpBranch:         state_d = StBranch;
                    default:          state_d = StTrap;
                endcase
            end
            StExecR: begin
                alu_src_a = 2'b10;
                state_d   = StTrap;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    state_d = StAluWb;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    alu_ctrl = 3'b001;
                    state_d  = StAluWb;
                end
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (funct3 == 3'b000) ? StAluWb : StTrap;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = is_store ? 2'b01 : 2'b00;
                if (funct3 != 3'b010) state_d = StTrap;
                else                  state_d = is_store ? StMemWr : StMemRd;
            end
            StMemRd: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_ctrl  = 3'b001;
                case (funct3)
                    3'b000: begin
                        pc_write = bus.zero;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    3'b001: begin
                        pc_write = !bus.zero;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    default: state_d = StTrap;
                endcase
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset gates every output combinationally so enables drop without a clock edge.
    assign bus.PCWrite   = rst & pc_write;
    assign bus.IRWrite   = rst & ir_write;
    assign bus.AdrSrc    = rst & adr_src;
    assign bus.MemRead   = rst & mem_read;
    assign bus.MemWrite  = rst & mem_write;
    assign bus.RegWrite  = rst & reg_write;
    assign bus.ALUSrcA   = rst ? alu_src_a  : 2'b00;
    assign bus.ALUSrcB   = rst ? alu_src_b  : 2'b00;
    assign bus.ALUctrl   = rst ? alu_ctrl   : 3'b000;
    assign bus.ResultSrc = rst ? result_src : 2'b00;
    assign bus.ImmSrc    = rst ? imm_src    : 2'b00;
    assign bus.illegal   = rst & illegal;
    assign bus.retire    = rst & retire;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle RV32I core. It sequences the shared ALU, sign-extension unit, register file, instruction register and unified memory port, one instruction at a time. It decodes the registered instruction word, drives the sign-extension unit's `ImmSrc` select, and stalls on a variable-latency memory through a `mem_ready` handshake. Supported instructions are add, sub, addi, lw, sw, beq and bne; every other encoding traps.

## Interface
- `DATA_WIDTH`, 32: instruction width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instr` in DATA_WIDTH: instruction register output; stable from the end of FETCH.
- `zero` in 1: ALU zero flag, valid in the BRANCH cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC load enable.
- `IRWrite` out 1: instruction register load enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: ALU B select. 00 = rs2, 01 = ImmOp, 10 = constant 4.
- `ALUctrl` out 3: ALU operation. 000 = add, 001 = sub.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ImmSrc` out 2: immediate format. 00 = I, 01 = S, 10 = B.
- `illegal` out 1: sticky trap flag.
- `retire` out 1: one-cycle pulse as each instruction completes.

## Operation
- The state register resets to FETCH.
- All outputs are combinational decodes of state, plus the listed `mem_ready` and `zero` gating.
- Any output not listed for a state is 0.

States and actions:
- **FETCH**
  - Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - PCWrite and IRWrite equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**
  - Drives ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add, which precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 → MEM_ADR
    - 0100011 → MEM_ADR
    - 1100011 → BRANCH
    - anything else → TRAP
- **EXEC_R**: ALUSrcA=10, ALUSrcB=00.
  - funct3=000, funct7=0000000: add.
  - funct3=000, funct7=0100000: sub.
  - Any other funct3/funct7 goes to TRAP; otherwise the next state is ALU_WB.
- **EXEC_I**: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, add. funct3≠000 goes to TRAP; otherwise ALU_WB.
- **MEM_ADR**: ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for a load, 01 for a store.
  - funct3≠010 goes to TRAP; otherwise MEM_RD for a load, MEM_WR for a store.
- **MEM_RD**: AdrSrc=1, MemRead=1. Holds until `mem_ready`, then MEM_WB.
- **MEM_WB**: ResultSrc=01, RegWrite=1, retire=1, then FETCH.
- **MEM_WR**: AdrSrc=1, MemWrite=1. Holds until `mem_ready`; then retire=1 and FETCH.
- **ALU_WB**: ResultSrc=00, RegWrite=1, retire=1, then FETCH.
- **BRANCH**: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, retire=1, then FETCH.
  - funct3=000 (beq): PCWrite = `zero`.
  - funct3=001 (bne): PCWrite = `!zero`.
  - Any other funct3 goes to TRAP with no PCWrite and no retire.
- **TRAP**
  - `illegal`=1; all enables are 0.
  - Absorbing state: only reset leaves it.

Rules:
- `instr` is sampled only in DECODE and later states. It is ignored in FETCH.
- At most one of MemRead and MemWrite is high in any cycle.
- RegWrite and MemWrite are never high in the same cycle.

## Timing
- **Reset value, all outputs 0**: while `rst`=0, every output is forced to 0, including `illegal`.
- **Reset value, after release**: on the first rising edge after `rst`=1 the FSM is in FETCH. The FETCH decodes apply from release; the state register itself changes only on clock edges.
- **Reset mid-operation**: an asynchronous assertion mid-instruction drops MemWrite, RegWrite and PCWrite in the same cycle. The partial instruction is abandoned, and no state beyond FETCH is retained.
- **Latency with `mem_ready` tied high**:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
- **Wait states**: each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Request outputs are held constant throughout the wait.
- **Handshake**: completion is the cycle in which the request is high and `mem_ready`=1. `mem_ready` in any other state is ignored.
- **`retire`**: exactly one pulse per completed instruction, in its final cycle. Never asserted in TRAP.

## Test plan
- **add x3,x1,x2 (0x002081B3), `mem_ready`=1**: states FETCH→DECODE→EXEC_R→ALU_WB. RegWrite=1 only in cycle 4; ALUctrl=000 in EXEC_R; retire in cycle 4.
- **lw x5,8(x1) (0x0080A283), `mem_ready` low for 3 cycles in MEM_RD**: MemRead=1 and AdrSrc=1 held for 4 cycles, then MEM_WB with ResultSrc=01 and RegWrite=1. Total 8 cycles.
- **sw x5,4(x1) (0x0050A223)**: ImmSrc=01 in MEM_ADR; MemWrite=1 exactly one cycle with `mem_ready`=1; RegWrite never asserted.
- **beq (0x00208463) with `zero`=1, then `zero`=0**: PCWrite=1 in BRANCH for the first case and 0 for the second. Repeat with bne (0x00209463): results inverted.
- **Illegal opcode 0x0000007F**: DECODE→TRAP. `illegal`=1 stays high for 20+ cycles with no enables; after a reset pulse, `illegal`=0 and the FSM is back in FETCH.
- **Reset asserted in MEM_WR while MemWrite=1**: MemWrite=0 in the same cycle without waiting for a clock edge. After release the FSM restarts in FETCH.
